player_move_ctrl: RTL and testbench
===================================

PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 2, pixels moved per accepted frame move.
REQ-002 SHALL have parameter ORIGIN_X, default 15, and ORIGIN_Y, default 48, the screen coordinates of arena tile (0,0).
REQ-003 SHALL have parameter CHECK_LAT, default 2, cycles from candidate drive to a stable valid_player_position.
REQ-004 SHALL have parameter BOMB_COOLDOWN, default 120, frames between accepted bomb requests.
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  asynchronous, active-low reset.
REQ-007 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-008 key_up, key_down, key_left, key_right  in  1 each  level direction requests.
REQ-009 key_bomb  in  1  level bomb request.
REQ-010 valid_player_position  in  1  collision-checker verdict for candidate_topLeftX/Y.
REQ-011 candidate_topLeftX, candidate_topLeftY  out  11 each  position under test, driven to the checker.
REQ-012 check_en  out  1  high while the checker must evaluate; drives the checker's InsideRectangle.
REQ-013 player_topLeftX, player_topLeftY  out  11 each  committed player position.
REQ-014 bomb_placed  out  1  one-cycle pulse on an accepted bomb.
REQ-015 bomb_tileX  out  5, bomb_tileY  out  4  tile of the accepted bomb, held until the next accepted bomb.

Function
REQ-016 SHALL implement FSM states IDLE, PROPOSE, WAIT, DECIDE.
REQ-017 IDLE->PROPOSE on startOfFrame when exactly one axis has a key pressed after priority (up>down>left>right); otherwise SHALL remain in IDLE.
REQ-018 PROPOSE SHALL load candidate = committed position +/- STEP on the selected axis and SHALL assert check_en; next state WAIT.
REQ-019 WAIT SHALL hold candidate and check_en for CHECK_LAT cycles via a down-counter, then go to DECIDE.
REQ-020 DECIDE SHALL commit candidate to player_topLeftX/Y if valid_player_position=1, else keep the old position; check_en low; next state IDLE.
REQ-021 Arena bounds SHALL be X in [ORIGIN_X, ORIGIN_X+18*32] and Y in [ORIGIN_Y, ORIGIN_Y+12*32]; a candidate outside them SHALL be rejected in DECIDE regardless of valid_player_position.
REQ-022 Arithmetic SHALL be 11-bit unsigned; underflow below ORIGIN SHALL be treated as out of bounds, never wrap to a legal value.
REQ-023 When check_en is low, candidate outputs SHALL equal the committed position.
REQ-024 startOfFrame arriving outside IDLE SHALL be ignored; no move is queued.
REQ-025 At most one committed move per frame; latency from startOfFrame to commit = CHECK_LAT+2 cycles.
REQ-026 Bomb: on startOfFrame with key_bomb=1 and cooldown counter=0, SHALL pulse bomb_placed for one cycle, latch bomb_tileX=(player_topLeftX-ORIGIN_X+16)>>5 and bomb_tileY=(player_topLeftY-ORIGIN_Y+16)>>5, and load the cooldown counter with BOMB_COOLDOWN.
REQ-027 The cooldown counter SHALL decrement once per startOfFrame down to 0 and saturate there.
REQ-028 Bomb handling SHALL run independently of the move FSM; a simultaneous move and bomb in the same frame SHALL use the pre-move position for the bomb tile.

Reset
REQ-029 On resetN low: FSM=IDLE, player_topLeftX=ORIGIN_X, player_topLeftY=ORIGIN_Y, candidate=committed, check_en=0, bomb_placed=0, bomb_tileX=0, bomb_tileY=0, cooldown=0, WAIT counter=0.
REQ-030 Reset asserted mid-check SHALL abort the check with no commit.

Structure
REQ-031 Tile size 32, arena 19x13 tiles, ORIGIN defaults and the FSM state enum SHALL live in the shared game package.
REQ-032 The bomb cooldown and tile latch SHALL be a sub-module named bomb_request_gen.

Verification
REQ-033 Reset, then frame with key_right, valid=1 -> after 4 cycles player_topLeftX=17, Y=48.
REQ-034 From (15,48), frame with key_left -> candidate 13 out of bounds, no commit, X stays 15.
REQ-035 From (47,48), key_down, valid=0 -> check_en high for 3 cycles, Y stays 48.
REQ-036 key_up+key_right together from (15,80), valid=1 -> Y=78, X=15 (up wins).
REQ-037 key_bomb held at (47,80) -> bomb_placed pulses, tile (1,1); next pulse only after 120 frames.
REQ-038 resetN pulsed during WAIT -> position returns to (15,48), check_en=0, no commit afterwards.

Source files
------------

// File: rtl/player_move_ctrl_pkg.sv
// Shared game constants and types for player movement.
// Tile geometry, arena size, default origin and FSM/direction enums.
package player_move_ctrl_pkg;

  localparam int POS_W         = 11;
  localparam int TILE_SIZE     = 32;
  localparam int ARENA_TILES_X = 19;
  localparam int ARENA_TILES_Y = 13;
  localparam int ORIGIN_X_DEF  = 15;
  localparam int ORIGIN_Y_DEF  = 48;

  typedef enum logic [1:0] {
    IDLE,
    PROPOSE,
    WAIT,
    DECIDE
  } move_state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } move_dir_t;

endpackage

// File: rtl/player_move_ctrl_if.sv
// Bus between the move controller and the collision checker.
// master: candidate position + check_en out, verdict in.
interface player_move_ctrl_if;

  logic [player_move_ctrl_pkg::POS_W-1:0] candidate_topLeftX;
  logic [player_move_ctrl_pkg::POS_W-1:0] candidate_topLeftY;
  logic check_en;
  logic valid_player_position;

  modport master (
    output candidate_topLeftX,
    output candidate_topLeftY,
    output check_en,
    input  valid_player_position
  );

  modport slave (
    input  candidate_topLeftX,
    input  candidate_topLeftY,
    input  check_en,
    output valid_player_position
  );

endinterface

// File: rtl/bomb_request_gen.sv
// Bomb request gate: frame-based cooldown and bomb tile latch.
// Ports: clk, resetN, startOfFrame, key_bomb, playerX/Y in; bomb_placed, bomb_tileX/Y out.
module bomb_request_gen
  import player_move_ctrl_pkg::*;
#(
  parameter int ORIGIN_X      = ORIGIN_X_DEF,
  parameter int ORIGIN_Y      = ORIGIN_Y_DEF,
  parameter int BOMB_COOLDOWN = 120
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             key_bomb,
  input  logic [POS_W-1:0] playerX,
  input  logic [POS_W-1:0] playerY,
  output logic             bomb_placed,
  output logic [4:0]       bomb_tileX,
  output logic [3:0]       bomb_tileY
);

  localparam int COOL_W = $clog2(BOMB_COOLDOWN + 1);

  logic [COOL_W-1:0] cooldown;
  logic [POS_W-1:0]  offX;
  logic [POS_W-1:0]  offY;
  logic              accept;

  // +16 rounds the top-left corner to the nearest tile
  assign offX   = playerX - POS_W'(ORIGIN_X) + POS_W'(16);
  assign offY   = playerY - POS_W'(ORIGIN_Y) + POS_W'(16);
  assign accept = startOfFrame && key_bomb && (cooldown == '0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cooldown    <= '0;
      bomb_placed <= 1'b0;
      bomb_tileX  <= '0;
      bomb_tileY  <= '0;
    end else begin
      bomb_placed <= accept;
      if (accept) begin
        cooldown   <= COOL_W'(BOMB_COOLDOWN);
        bomb_tileX <= 5'(offX >> 5);
        bomb_tileY <= 4'(offY >> 5);
      end else if (startOfFrame && cooldown != '0) begin
        cooldown <= cooldown - 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Per-frame player move: propose, wait for checker, commit; plus bomb gate.
// Ports: clk, resetN, startOfFrame, keys, checkBus (checker), player pos, bomb outputs.
module player_move_ctrl
  import player_move_ctrl_pkg::*;
#(
  parameter int STEP          = 2,
  parameter int ORIGIN_X      = ORIGIN_X_DEF,
  parameter int ORIGIN_Y      = ORIGIN_Y_DEF,
  parameter int CHECK_LAT     = 2,
  parameter int BOMB_COOLDOWN = 120
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_bomb,
  player_move_ctrl_if.master checkBus,
  output logic [POS_W-1:0] player_topLeftX,
  output logic [POS_W-1:0] player_topLeftY,
  output logic             bomb_placed,
  output logic [4:0]       bomb_tileX,
  output logic [3:0]       bomb_tileY
);

  localparam int CNT_W = $clog2(CHECK_LAT + 1);
  localparam logic [POS_W:0] MIN_X = (POS_W+1)'(ORIGIN_X);
  localparam logic [POS_W:0] MIN_Y = (POS_W+1)'(ORIGIN_Y);
  localparam logic [POS_W:0] MAX_X =
    (POS_W+1)'(ORIGIN_X + (ARENA_TILES_X - 1) * TILE_SIZE);
  localparam logic [POS_W:0] MAX_Y =
    (POS_W+1)'(ORIGIN_Y + (ARENA_TILES_Y - 1) * TILE_SIZE);

  move_state_t      state;
  move_state_t      nextState;
  move_dir_t        dir;
  move_dir_t        selDir;
  logic [CNT_W-1:0] cnt;
  logic             anyKey;
  logic             checkEn;
  logic             commitEn;
  logic [POS_W:0]   candX;
  logic [POS_W:0]   candY;
  logic             inBounds;

  assign anyKey = key_up | key_down | key_left | key_right;

  always_comb begin
    selDir = DIR_RIGHT;
    unique case (1'b1)
      key_up:                          selDir = DIR_UP;
      !key_up && key_down:             selDir = DIR_DOWN;
      !key_up && !key_down && key_left: selDir = DIR_LEFT;
      default:                         selDir = DIR_RIGHT;
    endcase
  end

  // Extra MSB catches underflow/overflow so it fails the bounds test
  always_comb begin
    candX = {1'b0, player_topLeftX};
    candY = {1'b0, player_topLeftY};
    unique case (dir)
      DIR_UP:    candY = {1'b0, player_topLeftY} - (POS_W+1)'(STEP);
      DIR_DOWN:  candY = {1'b0, player_topLeftY} + (POS_W+1)'(STEP);
      DIR_LEFT:  candX = {1'b0, player_topLeftX} - (POS_W+1)'(STEP);
      DIR_RIGHT: candX = {1'b0, player_topLeftX} + (POS_W+1)'(STEP);
    endcase
  end

  assign inBounds = (candX >= MIN_X) && (candX <= MAX_X) &&
                    (candY >= MIN_Y) && (candY <= MAX_Y);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (startOfFrame && anyKey) nextState = PROPOSE;
      PROPOSE: nextState = WAIT;
      WAIT:    if (cnt == '0) nextState = DECIDE;
      DECIDE:  nextState = IDLE;
    endcase
  end

  always_comb begin
    checkEn  = 1'b0;
    commitEn = 1'b0;
    unique case (state)
      IDLE:    ;
      PROPOSE: checkEn = 1'b1;
      WAIT:    checkEn = 1'b1;
      DECIDE:  commitEn = checkBus.valid_player_position && inBounds;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dir             <= DIR_UP;
      cnt             <= '0;
      player_topLeftX <= POS_W'(ORIGIN_X);
      player_topLeftY <= POS_W'(ORIGIN_Y);
    end else begin
      if (state == IDLE && startOfFrame && anyKey) dir <= selDir;
      if (state == PROPOSE) cnt <= CNT_W'(CHECK_LAT - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (commitEn) begin
        player_topLeftX <= candX[POS_W-1:0];
        player_topLeftY <= candY[POS_W-1:0];
      end
    end
  end

  assign checkBus.check_en = checkEn;
  assign checkBus.candidate_topLeftX =
    checkEn ? candX[POS_W-1:0] : player_topLeftX;
  assign checkBus.candidate_topLeftY =
    checkEn ? candY[POS_W-1:0] : player_topLeftY;

  bomb_request_gen #(
    .ORIGIN_X      (ORIGIN_X),
    .ORIGIN_Y      (ORIGIN_Y),
    .BOMB_COOLDOWN (BOMB_COOLDOWN)
  ) u_bomb (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .key_bomb     (key_bomb),
    .playerX      (player_topLeftX),
    .playerY      (player_topLeftY),
    .bomb_placed  (bomb_placed),
    .bomb_tileX   (bomb_tileX),
    .bomb_tileY   (bomb_tileY)
  );

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: frame stimulus, reference model, scoreboard.
// Expectations are pushed at drive time and popped after the frame completes.
module tb_player_move_ctrl;
  import player_move_ctrl_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  logic sof;
  logic ku, kd, kl, kr, kb;
  logic [10:0] px, py;
  logic bp;
  logic [4:0] btx;
  logic [3:0] bty;

  player_move_ctrl_if chkIf();

  player_move_ctrl dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (sof),
    .key_up          (ku),
    .key_down        (kd),
    .key_left        (kl),
    .key_right       (kr),
    .key_bomb        (kb),
    .checkBus        (chkIf),
    .player_topLeftX (px),
    .player_topLeftY (py),
    .bomb_placed     (bp),
    .bomb_tileX      (btx),
    .bomb_tileY      (bty)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;

  task automatic checkVal(input string tag, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
  endtask

  typedef struct {
    string tag;
    int preX;
    int candX;
    int candY;
    int x;
    int y;
    int ce;
    int bomb;
    int tx;
    int ty;
  } exp_t;

  exp_t sb[$];

  int mX, mY, mCool, mTx, mTy;

  task automatic modelReset();
    mX = 15; mY = 48; mCool = 0; mTx = 0; mTy = 0;
  endtask

  function automatic int modelBomb(input bit b);
    if (b && mCool == 0) begin
      mTx = ((mX - 15 + 16) / 32) & 31;
      mTy = ((mY - 48 + 16) / 32) & 15;
      mCool = 120;
      return 1;
    end
    if (mCool > 0) mCool--;
    return 0;
  endfunction

  task automatic doFrame(input string tag,
                         input bit u, input bit d,
                         input bit l, input bit r,
                         input bit b, input bit v,
                         input bit dbl = 1'b0);
    exp_t e;
    int cx, cy, ceCnt, pulses, xPre, cOx, cOy;
    bit move;
    e.tag = tag;
    e.preX = mX;
    e.bomb = modelBomb(b);
    move = u | d | l | r;
    cx = mX; cy = mY;
    if (u) cy -= 2;
    else if (d) cy += 2;
    else if (l) cx -= 2;
    else if (r) cx += 2;
    e.candX = move ? (cx & 2047) : mX;
    e.candY = move ? (cy & 2047) : mY;
    if (move && v && cx >= 15 && cx <= 15 + 18 * 32 &&
        cy >= 48 && cy <= 48 + 12 * 32) begin
      mX = cx; mY = cy;
    end
    if (dbl) void'(modelBomb(1'b0));
    e.x = mX; e.y = mY;
    e.ce = move ? 3 : 0;
    e.tx = mTx; e.ty = mTy;
    sb.push_back(e);

    @(negedge clk);
    ku = u; kd = d; kl = l; kr = r; kb = b;
    chkIf.valid_player_position = v;
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    ku = 0; kd = 0; kl = 0; kr = 0; kb = 0;
    ceCnt = 0; pulses = 0; xPre = 0; cOx = 0; cOy = 0;
    for (int i = 0; i < 6; i++) begin
      ceCnt += int'(chkIf.check_en);
      pulses += int'(bp);
      if (i == 1) begin
        cOx = int'(chkIf.candidate_topLeftX);
        cOy = int'(chkIf.candidate_topLeftY);
      end
      if (i == 3) xPre = int'(px);
      if (dbl && i == 1) begin
        ku = u; kd = d; kl = l; kr = r; sof = 1'b1;
      end
      if (dbl && i == 2) begin
        ku = 0; kd = 0; kl = 0; kr = 0; sof = 1'b0;
      end
      @(negedge clk);
    end

    e = sb.pop_front();
    checkVal({e.tag, "_xPre"}, xPre, e.preX);
    checkVal({e.tag, "_candX"}, cOx, e.candX);
    checkVal({e.tag, "_candY"}, cOy, e.candY);
    checkVal({e.tag, "_x"}, int'(px), e.x);
    checkVal({e.tag, "_y"}, int'(py), e.y);
    checkVal({e.tag, "_ce"}, ceCnt, e.ce);
    checkVal({e.tag, "_bomb"}, pulses, e.bomb);
    if (e.bomb != 0) begin
      checkVal({e.tag, "_tx"}, int'(btx), e.tx);
      checkVal({e.tag, "_ty"}, int'(bty), e.ty);
    end
  endtask

  initial begin
    int ceCnt;
    resetN = 1'b0;
    sof = 0; ku = 0; kd = 0; kl = 0; kr = 0; kb = 0;
    chkIf.valid_player_position = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkVal("rst_x", int'(px), 15);
    checkVal("rst_y", int'(py), 48);
    checkVal("rst_ce", int'(chkIf.check_en), 0);
    checkVal("rst_candX", int'(chkIf.candidate_topLeftX), 15);
    checkVal("rst_bomb", int'(bp), 0);
    checkVal("rst_tile", int'({btx, bty}), 0);
    resetN = 1'b1;

    doFrame("right", 0, 0, 0, 1, 0, 1);
    checkVal("right_x17", int'(px), 17);
    doFrame("left", 0, 0, 1, 0, 0, 1);
    doFrame("leftOob", 0, 0, 1, 0, 0, 1);
    checkVal("leftOob_x15", int'(px), 15);
    doFrame("dblSof", 0, 0, 0, 1, 0, 1, 1'b1);
    doFrame("back", 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 16; i++) doFrame("toX47", 0, 0, 0, 1, 0, 1);
    checkVal("x47", int'(px), 47);
    doFrame("downRej", 0, 1, 0, 0, 0, 0);
    checkVal("downRej_y48", int'(py), 48);
    doFrame("upOob", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) doFrame("toY80", 0, 1, 0, 0, 0, 1);
    checkVal("y80", int'(py), 80);

    doFrame("bomb", 0, 0, 0, 0, 1, 1);
    checkVal("bomb_tx1", int'(btx), 1);
    checkVal("bomb_ty1", int'(bty), 1);
    for (int i = 0; i < 121; i++) doFrame("bombHold", 0, 0, 0, 0, 1, 1);

    for (int i = 0; i < 16; i++) doFrame("toX15", 0, 0, 1, 0, 0, 1);
    doFrame("upRight", 1, 0, 0, 1, 0, 1);
    checkVal("upRight_y78", int'(py), 78);
    checkVal("upRight_x15", int'(px), 15);

    @(negedge clk);
    kr = 1'b1;
    chkIf.valid_player_position = 1'b1;
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0; kr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b0;
    modelReset();
    @(negedge clk);
    checkVal("midRst_x", int'(px), mX);
    checkVal("midRst_y", int'(py), mY);
    checkVal("midRst_ce", int'(chkIf.check_en), 0);
    resetN = 1'b1;
    ceCnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ceCnt += int'(chkIf.check_en);
    end
    checkVal("postRst_x", int'(px), 15);
    checkVal("postRst_ce", ceCnt, 0);
    doFrame("postRstMove", 0, 0, 0, 1, 0, 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
